approx_mult_err_mon: RTL and testbench

Hardware error-metric monitor for the 8-bit approximate multipliers: the receiving end of the multiplier characterisation flow. It consumes a stream of operand/approximate-product samples over a valid/ready handshake, recomputes the exact product, and accumulates error count, sum of absolute error distance and maximum error distance over a programmed number of samples. It sits after the multiplier under test on the characterisation path. The host derives ER, MED and MNED from the outputs; no division is done on chip.

---
 rtl/approx_mult_mon_pkg.sv | 22 ++
 rtl/approx_mult_err_mon_pipe.sv | 66 ++++++
 rtl/approx_mult_err_mon.sv | 126 ++++++++++++
 tb/tb_approx_mult_err_mon.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_mon_pkg.sv
// Shared types and width constants for the approximate-multiplier error monitor.
package approx_mult_mon_pkg;

    localparam int W_DEF = 8;
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mon_state_e;

    // Product width, and accumulator widths sized so 2^32-1 samples cannot overflow.
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    function automatic int sum_abs_w(input int w);
        return 2 * w + CNT_W;
    endfunction

    function automatic int sum_ed_w(input int w);
        return 2 * w + CNT_W + 1;
    endfunction

endpackage

// File: rtl/approx_mult_err_mon_pipe.sv
// Two-stage datapath: operand capture, then exact product with signed and absolute
// error distance against the approximate product.
module err_mon_pipe
    import approx_mult_mon_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic [2*W-1:0]       p_apprx,
    output logic                 s0_valid,
    output logic                 out_valid,
    output logic signed [2*W:0]  ed,
    output logic [2*W-1:0]       abs_ed,
    output logic                 err
);

    localparam int PW = prod_w(W);

    function automatic logic [PW-1:0] magnitude(input logic signed [PW:0] v);
        logic signed [PW:0] m;
        m = (v < 0) ? -v : v;
        return m[PW-1:0];
    endfunction

    logic          vld_p0, vld_p1;
    logic [W-1:0]  a_p0, b_p0;
    logic [PW-1:0] p_p0, exact_p1, p_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p0: operands captured on handshake
    always_ff @(posedge clk) begin
        if (in_valid) begin
            a_p0 <= a;
            b_p0 <= b;
            p_p0 <= p_apprx;
        end
    end

    // Stage p1: exact product alongside the approximate one
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            exact_p1 <= PW'(a_p0) * PW'(b_p0);
            p_p1     <= p_p0;
        end
    end

    assign ed        = $signed({1'b0, exact_p1}) - $signed({1'b0, p_p1});
    assign abs_ed    = magnitude(ed);
    assign err       = (ed != '0);
    assign s0_valid  = vld_p0;
    assign out_valid = vld_p1;

endmodule

// File: rtl/approx_mult_err_mon.sv
// Error-metric monitor: run FSM, sample counter and ER/MED/max accumulators.
// Optional signed error-sum accumulator enabled by ERR_MON_SIGNED_ED_EN.
module approx_mult_err_mon
    import approx_mult_mon_pkg::*;
#(
    parameter int          W         = W_DEF,
    parameter int unsigned N_SAMPLES = 1000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W-1:0]                  a,
    input  logic [W-1:0]                  b,
    input  logic [2*W-1:0]                p_apprx,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              sample_count,
    output logic [CNT_W-1:0]              err_count,
    output logic [2*W+CNT_W-1:0]          sum_abs_ed,
    output logic [2*W-1:0]                max_ed,
    output logic signed [2*W+CNT_W:0]     sum_ed
);

    localparam int PW  = prod_w(W);
    localparam int SAW = sum_abs_w(W);
    localparam int SEW = sum_ed_w(W);

    mon_state_e state, state_nxt;

    logic                hs, clear, last_acc;
    logic                pipe_s0_vld, pipe_vld, pipe_err;
    logic signed [PW:0]  pipe_ed;
    logic [PW-1:0]       pipe_abs;

    assign hs       = in_valid & in_ready;
    assign last_acc = in_valid && (sample_count == CNT_W'(N_SAMPLES - 1));

    err_mon_pipe #(.W(W)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (hs),
        .a         (a),
        .b         (b),
        .p_apprx   (p_apprx),
        .s0_valid  (pipe_s0_vld),
        .out_valid (pipe_vld),
        .ed        (pipe_ed),
        .abs_ed    (pipe_abs),
        .err       (pipe_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // DRAIN ends on the edge where the final sample leaves stage p1 into the accumulators
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_acc) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pipe_vld && !pipe_s0_vld) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count <= '0;
            err_count    <= '0;
            sum_abs_ed   <= '0;
            max_ed       <= '0;
        end else if (clear) begin
            sample_count <= '0;
            err_count    <= '0;
            sum_abs_ed   <= '0;
            max_ed       <= '0;
        end else begin
            if (hs) sample_count <= sample_count + 1'b1;
            if (pipe_vld) begin
                if (pipe_err) err_count <= err_count + 1'b1;
                sum_abs_ed <= sum_abs_ed + SAW'(pipe_abs);
                if (pipe_abs > max_ed) max_ed <= pipe_abs;
            end
        end
    end

`ifdef ERR_MON_SIGNED_ED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sum_ed <= '0;
        else if (clear)    sum_ed <= '0;
        else if (pipe_vld) sum_ed <= sum_ed + SEW'(pipe_ed);
    end
`else
    logic unused_ed;
    assign unused_ed = ^pipe_ed;
    assign sum_ed    = '0;
`endif

endmodule

// File: tb/tb_approx_mult_err_mon.sv
// Randomised and directed bench for approx_mult_err_mon against a statistics model.
module tb_approx_mult_err_mon;

    localparam int N = 4;

    logic               clk, rst, start, in_valid, in_ready, busy, done;
    logic [7:0]         a, b;
    logic [15:0]        p_apprx;
    logic [31:0]        sample_count, err_count;
    logic [47:0]        sum_abs_ed;
    logic [15:0]        max_ed;
    logic signed [48:0] sum_ed;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned qa[$], qb[$], qp[$];

    approx_mult_err_mon #(.W(8), .N_SAMPLES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .p_apprx      (p_apprx),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .sum_abs_ed   (sum_abs_ed),
        .max_ed       (max_ed),
        .sum_ed       (sum_ed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_cnt"},  sample_count, 0);
        check({tag, "_err"},  err_count, 0);
        check({tag, "_sum"},  sum_abs_ed, 0);
        check({tag, "_max"},  max_ed, 0);
        check({tag, "_sed"},  longint'(sum_ed), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int unsigned aa, input int unsigned bb, input int unsigned pp);
        int guard = 0;
        a        = 8'(aa);
        b        = 8'(bb);
        p_apprx  = 16'(pp);
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_directed();
        qa = '{3, 3, 255, 0};
        qb = '{5, 5, 255, 7};
        qp = '{15, 14, 64925, 3};
    endtask

    task automatic load_random();
        qa.delete(); qb.delete(); qp.delete();
        for (int i = 0; i < N; i++) begin
            int unsigned x, y, ex, pp;
            x  = $urandom_range(0, 255);
            y  = $urandom_range(0, 255);
            ex = x * y;
            case ($urandom_range(0, 3))
                0:       pp = ex;
                1:       pp = (ex + $urandom_range(1, 300)) & 32'hFFFF;
                2:       pp = $urandom_range(0, 65535);
                default: pp = (ex > 50) ? ex - $urandom_range(1, 50) : ex;
            endcase
            qa.push_back(x); qb.push_back(y); qp.push_back(pp);
        end
    endtask

    // gap < 0 picks a random bubble length per sample; poke >= 0 pulses start after that many samples
    task automatic run_and_check(input string tag, input int gap, input bit hold_valid, input int poke);
        longint errc = 0, sabs = 0, maxe = 0, sed = 0, ed, mag;
        foreach (qa[i]) begin
            ed  = longint'(qa[i] * qb[i]) - longint'(qp[i]);
            mag = (ed < 0) ? -ed : ed;
            if (ed != 0) errc++;
            sabs += mag;
            if (mag > maxe) maxe = mag;
            sed += ed;
        end
`ifndef ERR_MON_SIGNED_ED_EN
        sed = 0;
`endif
        do_start();
        check({tag, "_busy_start"}, busy, 1);
        check({tag, "_done_start"}, done, 0);
        check_cleared({tag, "_start"});
        foreach (qa[i]) begin
            int g;
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            if (i > 0) repeat (g) tick();
            if (i == poke) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check({tag, "_poke_cnt"}, sample_count, poke);
                check({tag, "_poke_busy"}, busy, 1);
            end
            send(qa[i], qb[i], qp[i]);
        end
        if (hold_valid) in_valid = 1'b1;
        check({tag, "_cnt_last"}, sample_count, N);
        check({tag, "_rdy_k"}, in_ready, 0);
        check({tag, "_done_k"}, done, 0);
        tick();
        check({tag, "_rdy_k1"}, in_ready, 0);
        check({tag, "_done_k1"}, done, 0);
        check({tag, "_busy_k1"}, busy, 1);
        tick();
        check({tag, "_done_k2"}, done, 1);
        check({tag, "_busy_k2"}, busy, 0);
        check({tag, "_cnt"}, sample_count, N);
        check({tag, "_err"}, err_count, errc);
        check({tag, "_sum"}, sum_abs_ed, sabs);
        check({tag, "_max"}, max_ed, maxe);
        check({tag, "_sed"}, longint'(sum_ed), sed);
        in_valid = 1'b0;
        tick();
        check({tag, "_done_hold"}, done, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; p_apprx = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_cleared("rst");
        rst = 1'b0;
        tick();

        load_directed();
        run_and_check("b2b", 0, 1'b0, -1);
        run_and_check("gap3", 3, 1'b1, -1);
        run_and_check("poke", 0, 1'b0, 2);

        do_start();
        send(3, 5, 15);
        send(3, 5, 14);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check_cleared("midrst");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("midrst_idle_busy", busy, 0);
        run_and_check("after_rst", 0, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            load_random();
            run_and_check("rnd", -1, 1'b0, -1);
        end

        qa = '{255, 0, 1, 2};
        qb = '{255, 0, 1, 3};
        qp = '{65025, 0, 1, 6};
        run_and_check("exact", 1, 1'b0, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done", done, 0);
        check("restart_busy", busy, 1);
        check_cleared("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
